// File: rtl/chess_clock_pkg.sv
// Shared definitions for the chess clock.
// Holds the turn-state encoding that chess_turn_ctrl drives on STATE and the
// display/mux stage decodes, plus the counter-clear pulse length.
// No ports: this file is a package only.

package chess_clock_pkg;

   // The numeric values are part of the STATE bus contract with the display stage.
   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StRunA   = 3'd1,
      StRunB   = 3'd2,
      StPauseA = 3'd3,
      StPauseB = 3'd4,
      StFlag   = 3'd5
   } turn_state_e;

   // CNT_CLR is held high for this many cycles whenever the game returns to idle.
   localparam int unsigned CntClrLen = 2;
   localparam int unsigned CntClrW   = $clog2(CntClrLen + 1);

   // True while one of the players' clocks is running.
   function automatic logic is_running(turn_state_e st);
      return (st == StRunA) || (st == StRunB);
   endfunction

endpackage

// File: rtl/chess_turn_ctrl_if.sv
// Button, timeout and counter-chain signals of the chess turn controller.
// Signals:
//   BTN_START, BTN_RESET, BTN_A, BTN_B : asynchronous button levels
//   TIMEOUT_A, TIMEOUT_B               : counter chain all-zero flags (synchronous)
//   CE_A, CE_B                         : per-player count enables
//   IMPULSE_A, IMPULSE_B               : one-cycle decrement pulses
//   CNT_CLR                            : clear/reload to the counter chains
//   FLAG_A, FLAG_B                     : flag-fallen indicators
//   STATE                              : current turn state encoding
// Modports:
//   master : the board side (buttons, counter chains, display)
//   slave  : the turn controller

interface chess_turn_ctrl_if;

   logic       BTN_START;
   logic       BTN_RESET;
   logic       BTN_A;
   logic       BTN_B;
   logic       TIMEOUT_A;
   logic       TIMEOUT_B;
   logic       CE_A;
   logic       CE_B;
   logic       IMPULSE_A;
   logic       IMPULSE_B;
   logic       CNT_CLR;
   logic       FLAG_A;
   logic       FLAG_B;
   logic [2:0] STATE;

   modport master (
      output BTN_START, BTN_RESET, BTN_A, BTN_B, TIMEOUT_A, TIMEOUT_B,
      input  CE_A, CE_B, IMPULSE_A, IMPULSE_B, CNT_CLR, FLAG_A, FLAG_B, STATE
   );

   modport slave (
      input  BTN_START, BTN_RESET, BTN_A, BTN_B, TIMEOUT_A, TIMEOUT_B,
      output CE_A, CE_B, IMPULSE_A, IMPULSE_B, CNT_CLR, FLAG_A, FLAG_B, STATE
   );

endinterface

// File: rtl/button_sync.sv
// Button synchroniser and press detector.
// Two flops bring the asynchronous button level into the CLK domain; a third
// flop remembers the previous synchronised level so that a rising edge yields a
// single-cycle PRESS, however long the button is held.
// Ports:
//   CLK   : system clock
//   CLR_N : asynchronous active-low reset, clears all three flops
//   BTN   : raw asynchronous button level
//   PRESS : one-cycle press pulse (combinational from flops)

module button_sync (
   input  logic CLK,
   input  logic CLR_N,
   input  logic BTN,
   output logic PRESS
);

   logic meta_q;
   logic sync_q;
   logic prev_q;

   always_ff @(posedge CLK or negedge CLR_N) begin
      if (!CLR_N) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         meta_q <= BTN;
         sync_q <= meta_q;
         prev_q <= sync_q;
      end
   end

   assign PRESS = sync_q & ~prev_q;

endmodule

// File: rtl/chess_turn_ctrl.sv
// Turn and time-base controller for the chess clock.
// Runs the turn state machine (idle, running, paused, flag fall) from the four
// synchronised buttons and the counter chains' timeout flags, and generates the
// per-player count enables and decrement impulses that drive the down-counter
// chains. Every output is a flop, so reset and state changes never glitch them.
// Parameters:
//   TICK_DIV : CLK cycles per decrement impulse, at least 2
// Ports:
//   CLK    : system clock, rising edge
//   CLR_N  : asynchronous active-low reset
//   tc_bus : chess_turn_ctrl_if slave modport (buttons, timeouts, outputs)

module chess_turn_ctrl
   import chess_clock_pkg::*;
#(
   parameter int unsigned TICK_DIV = 100_000_000
) (
   input logic              CLK,
   input logic              CLR_N,
   chess_turn_ctrl_if.slave tc_bus
);

   localparam int unsigned       PrescW   = $clog2(TICK_DIV);
   localparam logic [PrescW-1:0] PrescMax = PrescW'(TICK_DIV - 1);

   // Button presses, one cycle each.
   logic press_start;
   logic press_reset;
   logic press_a;
   logic press_b;

   turn_state_e        state_q, state_d;
   logic [PrescW-1:0]  presc_q, presc_d;
   logic [CntClrW-1:0] clr_left_q, clr_left_d;
   logic               cnt_clr_q, cnt_clr_d;
   logic               ce_a_q, ce_a_d;
   logic               ce_b_q, ce_b_d;
   logic               imp_a_q, imp_a_d;
   logic               imp_b_q, imp_b_d;
   logic               flag_a_q, flag_a_d;
   logic               flag_b_q, flag_b_d;

   logic tc;
   logic enter_idle;

   button_sync u_sync_start (
      .CLK   (CLK),
      .CLR_N (CLR_N),
      .BTN   (tc_bus.BTN_START),
      .PRESS (press_start)
   );

   button_sync u_sync_reset (
      .CLK   (CLK),
      .CLR_N (CLR_N),
      .BTN   (tc_bus.BTN_RESET),
      .PRESS (press_reset)
   );

   button_sync u_sync_a (
      .CLK   (CLK),
      .CLR_N (CLR_N),
      .BTN   (tc_bus.BTN_A),
      .PRESS (press_a)
   );

   button_sync u_sync_b (
      .CLK   (CLK),
      .CLR_N (CLR_N),
      .BTN   (tc_bus.BTN_B),
      .PRESS (press_b)
   );

   // Terminal count of the running player's prescaler.
   assign tc = is_running(state_q) && (presc_q == PrescMax);

   // Turn state machine. In a running state the flag fall outranks a pause, which
   // outranks ending the move, so a dead clock can never be handed over.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (press_start) state_d = StRunA;
         end
         StRunA: begin
            if (tc_bus.TIMEOUT_A)  state_d = StFlag;
            else if (press_start) state_d = StPauseA;
            else if (press_a)     state_d = StRunB;
         end
         StRunB: begin
            if (tc_bus.TIMEOUT_B)  state_d = StFlag;
            else if (press_start) state_d = StPauseB;
            else if (press_b)     state_d = StRunA;
         end
         StPauseA: begin
            if (press_start)      state_d = StRunA;
            else if (press_reset) state_d = StIdle;
         end
         StPauseB: begin
            if (press_start)      state_d = StRunB;
            else if (press_reset) state_d = StIdle;
         end
         StFlag: begin
            if (press_reset) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // Prescaler. A running cycle always advances it, including the cycle that
   // leads into a pause, so the phase seen after resuming still adds up to
   // TICK_DIV running cycles. A new turn restarts the phase from zero.
   always_comb begin
      presc_d = presc_q;
      if ((state_d == StIdle) || (state_d == StFlag)) begin
         presc_d = '0;
      end else if (is_running(state_q)) begin
         if (is_running(state_d) && (state_d != state_q)) begin
            presc_d = '0;
         end else if (tc) begin
            presc_d = '0;
         end else begin
            presc_d = presc_q + PrescW'(1);
         end
      end else if ((state_q == StIdle) && (state_d == StRunA)) begin
         presc_d = '0;
      end
   end

   // Registered outputs, decoded from the next state so they line up with STATE.
   always_comb begin
      enter_idle = (state_d == StIdle) && (state_q != StIdle);

      ce_a_d = (state_d == StRunA);
      ce_b_d = (state_d == StRunB);

      // The impulse only fires if the player keeps running; a flag fall or a
      // press landing on the terminal count swallows it so the chain never
      // decrements past zero or charges the wrong player.
      imp_a_d = tc && (state_q == StRunA) && (state_d == StRunA);
      imp_b_d = tc && (state_q == StRunB) && (state_d == StRunB);

      flag_a_d = flag_a_q;
      flag_b_d = flag_b_q;
      if (state_d == StIdle) begin
         flag_a_d = 1'b0;
         flag_b_d = 1'b0;
      end else if (state_d == StFlag) begin
         if (state_q == StRunA) flag_a_d = 1'b1;
         if (state_q == StRunB) flag_b_d = 1'b1;
      end

      // clr_left counts the CNT_CLR cycles still owed after the current one.
      if (enter_idle) begin
         cnt_clr_d  = 1'b1;
         clr_left_d = CntClrW'(CntClrLen - 1);
      end else if (clr_left_q != '0) begin
         cnt_clr_d  = 1'b1;
         clr_left_d = clr_left_q - CntClrW'(1);
      end else begin
         cnt_clr_d  = 1'b0;
         clr_left_d = '0;
      end
   end

   always_ff @(posedge CLK or negedge CLR_N) begin
      if (!CLR_N) begin
         state_q    <= StIdle;
         presc_q    <= '0;
         cnt_clr_q  <= 1'b1;
         clr_left_q <= CntClrW'(CntClrLen - 1);
         ce_a_q     <= 1'b0;
         ce_b_q     <= 1'b0;
         imp_a_q    <= 1'b0;
         imp_b_q    <= 1'b0;
         flag_a_q   <= 1'b0;
         flag_b_q   <= 1'b0;
      end else begin
         state_q    <= state_d;
         presc_q    <= presc_d;
         cnt_clr_q  <= cnt_clr_d;
         clr_left_q <= clr_left_d;
         ce_a_q     <= ce_a_d;
         ce_b_q     <= ce_b_d;
         imp_a_q    <= imp_a_d;
         imp_b_q    <= imp_b_d;
         flag_a_q   <= flag_a_d;
         flag_b_q   <= flag_b_d;
      end
   end

   assign tc_bus.STATE     = state_q;
   assign tc_bus.CE_A      = ce_a_q;
   assign tc_bus.CE_B      = ce_b_q;
   assign tc_bus.IMPULSE_A = imp_a_q;
   assign tc_bus.IMPULSE_B = imp_b_q;
   assign tc_bus.CNT_CLR   = cnt_clr_q;
   assign tc_bus.FLAG_A    = flag_a_q;
   assign tc_bus.FLAG_B    = flag_b_q;

endmodule

// File: tb/tb_chess_turn_ctrl.sv
// Self-checking bench for chess_turn_ctrl with TICK_DIV = 4.
// A behavioural game model (button latency rule, turn rules, running-cycle
// count per turn) predicts every output after every clock edge.

module tb_chess_turn_ctrl;

   localparam int TD = 4;

   localparam int S_IDLE    = 0;
   localparam int S_RUN_A   = 1;
   localparam int S_RUN_B   = 2;
   localparam int S_PAUSE_A = 3;
   localparam int S_PAUSE_B = 4;
   localparam int S_FLAG    = 5;

   logic clk = 1'b0;
   logic clr_n;

   chess_turn_ctrl_if tc_bus ();

   chess_turn_ctrl #(
      .TICK_DIV (TD)
   ) dut (
      .CLK    (clk),
      .CLR_N  (clr_n),
      .tc_bus (tc_bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Model state.
   int       m_state;
   int       m_run;       // running cycles completed in the current turn
   bit       m_imp_a, m_imp_b;
   bit       m_flag_a, m_flag_b;
   int       m_clr_left;  // cycles CNT_CLR is still high, including this one
   bit [3:0] h1, h2, h3;  // button levels sampled 1/2/3 edges ago: start, reset, a, b

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_state    = S_IDLE;
      m_run      = 0;
      m_imp_a    = 1'b0;
      m_imp_b    = 1'b0;
      m_flag_a   = 1'b0;
      m_flag_b   = 1'b0;
      m_clr_left = 2;
      h1 = '0;
      h2 = '0;
      h3 = '0;
   endtask

   // Advance the model across one rising edge using the inputs present at it.
   task automatic model_edge();
      bit [3:0] lvl;
      bit [3:0] press;
      int       nxt;
      lvl   = {tc_bus.BTN_B, tc_bus.BTN_A, tc_bus.BTN_RESET, tc_bus.BTN_START};
      // A level first sampled at edge k acts at edge k+2.
      press = h2 & ~h3;
      h3 = h2;
      h2 = h1;
      h1 = lvl;

      nxt = m_state;
      case (m_state)
         S_IDLE:    if (press[0]) nxt = S_RUN_A;
         S_RUN_A: begin
            if (tc_bus.TIMEOUT_A)  nxt = S_FLAG;
            else if (press[0])    nxt = S_PAUSE_A;
            else if (press[2])    nxt = S_RUN_B;
         end
         S_RUN_B: begin
            if (tc_bus.TIMEOUT_B)  nxt = S_FLAG;
            else if (press[0])    nxt = S_PAUSE_B;
            else if (press[3])    nxt = S_RUN_A;
         end
         S_PAUSE_A: begin
            if (press[0])      nxt = S_RUN_A;
            else if (press[1]) nxt = S_IDLE;
         end
         S_PAUSE_B: begin
            if (press[0])      nxt = S_RUN_B;
            else if (press[1]) nxt = S_IDLE;
         end
         S_FLAG:    if (press[1]) nxt = S_IDLE;
         default:   nxt = S_IDLE;
      endcase

      m_imp_a = 1'b0;
      m_imp_b = 1'b0;
      if (m_state == S_RUN_A || m_state == S_RUN_B) begin
         m_run++;
         if (nxt == m_state && (m_run % TD) == 0) begin
            if (m_state == S_RUN_A) m_imp_a = 1'b1;
            else                    m_imp_b = 1'b1;
         end
      end
      // A resumed turn keeps its phase; any other start of a turn begins afresh.
      if ((nxt == S_RUN_A && m_state != S_RUN_A && m_state != S_PAUSE_A) ||
          (nxt == S_RUN_B && m_state != S_RUN_B && m_state != S_PAUSE_B)) begin
         m_run = 0;
      end

      if (nxt == S_FLAG && m_state == S_RUN_A) m_flag_a = 1'b1;
      if (nxt == S_FLAG && m_state == S_RUN_B) m_flag_b = 1'b1;
      if (nxt == S_IDLE) begin
         m_flag_a = 1'b0;
         m_flag_b = 1'b0;
      end

      if (nxt == S_IDLE && m_state != S_IDLE) m_clr_left = 2;
      else if (m_clr_left > 0)               m_clr_left--;

      m_state = nxt;
   endtask

   task automatic compare_all();
      check_eq("state",     32'(tc_bus.STATE),     32'(m_state));
      check_eq("ce_a",      32'(tc_bus.CE_A),      32'(m_state == S_RUN_A));
      check_eq("ce_b",      32'(tc_bus.CE_B),      32'(m_state == S_RUN_B));
      check_eq("impulse_a", 32'(tc_bus.IMPULSE_A), 32'(m_imp_a));
      check_eq("impulse_b", 32'(tc_bus.IMPULSE_B), 32'(m_imp_b));
      check_eq("cnt_clr",   32'(tc_bus.CNT_CLR),   32'(m_clr_left > 0));
      check_eq("flag_a",    32'(tc_bus.FLAG_A),    32'(m_flag_a));
      check_eq("flag_b",    32'(tc_bus.FLAG_B),    32'(m_flag_b));
   endtask

   // Drive inputs away from the edge, clock once, predict and compare.
   task automatic step(input bit bs, input bit br, input bit ba, input bit bb,
                       input bit ta, input bit tb);
      tc_bus.BTN_START = bs;
      tc_bus.BTN_RESET = br;
      tc_bus.BTN_A     = ba;
      tc_bus.BTN_B     = bb;
      tc_bus.TIMEOUT_A = ta;
      tc_bus.TIMEOUT_B = tb;
      @(posedge clk);
      model_edge();
      #1 compare_all();
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
   endtask

   task automatic hold_btn(input int which, input int n);
      for (int i = 0; i < n; i++) begin
         step(which == 0, which == 1, which == 2, which == 3, 0, 0);
      end
   endtask

   // Step until the model is in state st with ph running cycles done (mod TD).
   task automatic wait_phase(input int st, input int ph);
      int budget;
      bit found;
      budget = 60;
      found  = 1'b0;
      while (!found && budget > 0) begin
         if (m_state == st && (m_run % TD) == ph) found = 1'b1;
         else begin
            step(0, 0, 0, 0, 0, 0);
            budget--;
         end
      end
      check_eq("wait_phase", 32'(found), 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, expected end by 2 ms");
      $fatal(1, "watchdog");
   end

   initial begin
      int       clr_hi;
      bit [3:0] lvl;

      tc_bus.BTN_START = 1'b0;
      tc_bus.BTN_RESET = 1'b0;
      tc_bus.BTN_A     = 1'b0;
      tc_bus.BTN_B     = 1'b0;
      tc_bus.TIMEOUT_A = 1'b0;
      tc_bus.TIMEOUT_B = 1'b0;
      clr_n = 1'b1;
      #2 clr_n = 1'b0;
      #1;
      model_reset();
      compare_all();
      repeat (2) begin
         @(posedge clk);
         #1 compare_all();
      end
      @(negedge clk) clr_n = 1'b1;

      // Reset release: CNT_CLR drops on the second edge.
      idle_cycles(4);

      // Start from idle, then let A's clock run through several impulses.
      hold_btn(0, 3);
      idle_cycles(14);

      // Player A holds the move button: exactly one switch to B.
      hold_btn(2, 20);
      idle_cycles(10);

      // Back to A, then pause/resume at every prescaler phase.
      hold_btn(3, 2);
      idle_cycles(4);
      for (int p = 0; p < TD; p++) begin
         wait_phase(S_RUN_A, p);
         hold_btn(0, 2);
         idle_cycles(10);
         hold_btn(0, 2);
         idle_cycles(7);
      end

      // Timeout in the terminal-count cycle: flag wins, impulse swallowed.
      wait_phase(S_RUN_A, TD - 1);
      step(0, 0, 0, 0, 1, 0);
      check_eq("tc_flag_state", 32'(tc_bus.STATE),     32'(S_FLAG));
      check_eq("tc_flag_a",     32'(tc_bus.FLAG_A),    32'd1);
      check_eq("tc_no_impulse", 32'(tc_bus.IMPULSE_A), 32'd0);
      idle_cycles(3);
      clr_hi = 0;
      for (int i = 0; i < 10; i++) begin
         step(0, i < 2, 0, 0, 0, 0);
         if (tc_bus.CNT_CLR) clr_hi++;
      end
      check_eq("cnt_clr_len", 32'(clr_hi), 32'd2);

      // Asynchronous reset in the middle of B's turn, just before a terminal count.
      hold_btn(0, 2);
      idle_cycles(3);
      hold_btn(2, 2);
      idle_cycles(2);
      wait_phase(S_RUN_B, TD - 1);
      #2 clr_n = 1'b0;
      #1;
      model_reset();
      compare_all();
      repeat (2) begin
         @(posedge clk);
         #1 compare_all();
      end
      @(negedge clk) clr_n = 1'b1;
      idle_cycles(12);

      // Random play.
      lvl = '0;
      for (int i = 0; i < 3000; i++) begin
         bit ta;
         bit tb;
         for (int b = 0; b < 4; b++) begin
            if (b == 1) begin
               if ($urandom_range(0, 39) == 0) lvl[b] = ~lvl[b];
            end else if ($urandom_range(0, 5) == 0) begin
               lvl[b] = ~lvl[b];
            end
         end
         ta = ($urandom_range(0, 59) == 0);
         tb = ($urandom_range(0, 59) == 0);
         step(lvl[0], lvl[1], lvl[2], lvl[3], ta, tb);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
